// File: rtl/priority_decoder_2to4_pulse.sv
// ----------------------------------------------------------------------------
// priority_decoder_2to4_pulse : (Y,V) code -> timed one-hot pulse on D0..D3
// with BUSY/DONE handshake and sticky overrun flag.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module priority_decoder_2to4_pulse #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Y,
  input  logic       V,
  input  logic       CLR_OVR,
  output logic       D0,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       onehot_q, onehot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        onehot_d = 4'b0000;
        busy_d   = 1'b0;
        if (V) begin
          state_d  = DRIVE;
          cnt_d    = LOAD_VAL;
          onehot_d = 4'b0001 << Y;
          busy_d   = 1'b1;
        end
      end
      DRIVE: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d  = GAP;
          onehot_d = 4'b0000;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        state_d  = IDLE;
        onehot_d = 4'b0000;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        onehot_d = 4'b0000;
        busy_d   = 1'b0;
      end
    endcase
  end

  // A code offered while busy is dropped; setting beats a same-edge clear.
  always_comb begin
    ovr_d = ovr_q;
    if (V && busy_q) begin
      ovr_d = 1'b1;
    end else if (CLR_OVR) begin
      ovr_d = 1'b0;
    end
  end

  assign D0   = onehot_q[0];
  assign D1   = onehot_q[1];
  assign D2   = onehot_q[2];
  assign D3   = onehot_q[3];
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OVR  = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_priority_decoder_2to4_pulse.sv
// ----------------------------------------------------------------------------
// tb_priority_decoder_2to4_pulse : directed bench for PULSE_LEN=4 and =1 builds.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_priority_decoder_2to4_pulse;

  logic       clk = 1'b0;
  logic       rst, v, clr;
  logic [1:0] y;
  logic       d0, d1, d2, d3, busy, done, ovr;

  logic       rst_b, v_b, clr_b;
  logic [1:0] y_b;
  logic       e0, e1, e2, e3, busy_b, done_b, ovr_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  priority_decoder_2to4_pulse #(.PULSE_LEN(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .Y(y), .V(v), .CLR_OVR(clr),
    .D0(d0), .D1(d1), .D2(d2), .D3(d3),
    .BUSY(busy), .DONE(done), .OVR(ovr)
  );

  priority_decoder_2to4_pulse #(.PULSE_LEN(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst_b), .Y(y_b), .V(v_b), .CLR_OVR(clr_b),
    .D0(e0), .D1(e1), .D2(e2), .D3(e3),
    .BUSY(busy_b), .DONE(done_b), .OVR(ovr_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Status of the PULSE_LEN=4 instance: {D3..D0, BUSY, DONE, OVR}.
  task automatic chk4(input string tag, input logic [3:0] d, input logic b,
                      input logic dn, input logic o);
    check(tag, {1'b0, d3, d2, d1, d0, busy, done, ovr}, {1'b0, d, b, dn, o});
  endtask

  task automatic chk1(input string tag, input logic [3:0] d, input logic b,
                      input logic dn, input logic o);
    check(tag, {1'b0, e3, e2, e1, e0, busy_b, done_b, ovr_b}, {1'b0, d, b, dn, o});
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; v = 1'b1; y = 2'd3; clr = 1'b0;
    rst_b = 1'b1; v_b = 1'b1; y_b = 2'd3; clr_b = 1'b0;

    // Reset held two edges with a valid code present.
    tick(); chk4("reset_e1", 4'b0000, 0, 0, 0);
    tick(); chk4("reset_e2", 4'b0000, 0, 0, 0);
    chk1("reset_b", 4'b0000, 0, 0, 0);
    rst = 1'b0; v = 1'b0; rst_b = 1'b0; v_b = 1'b0;
    tick(); chk4("post_reset", 4'b0000, 0, 0, 0);

    // Full sweep: 4 cycles of D[Y], one GAP with DONE, then idle.
    for (int i = 0; i < 4; i++) begin
      v = 1'b1; y = 2'(i);
      tick(); v = 1'b0;
      chk4($sformatf("sweep%0d_c0", i), 4'b0001 << i, 1, 0, 0);
      for (int k = 1; k < 4; k++) begin
        tick(); chk4($sformatf("sweep%0d_c%0d", i, k), 4'b0001 << i, 1, 0, 0);
      end
      tick(); chk4($sformatf("sweep%0d_gap", i), 4'b0000, 1, 1, 0);
      tick(); chk4($sformatf("sweep%0d_idle", i), 4'b0000, 0, 0, 0);
    end

    // Y changes during DRIVE are ignored.
    v = 1'b1; y = 2'd1;
    tick(); v = 1'b0; y = 2'd3;
    chk4("ychg_c0", 4'b0010, 1, 0, 0);
    for (int k = 1; k < 4; k++) begin
      tick(); chk4("ychg_ck", 4'b0010, 1, 0, 0);
    end
    tick(); chk4("ychg_gap", 4'b0000, 1, 1, 0);
    tick(); chk4("ychg_idle", 4'b0000, 0, 0, 0);

    // Overrun on the second DRIVE edge.
    v = 1'b1; y = 2'd2;
    tick(); y = 2'd0;
    chk4("ovr_c0", 4'b0100, 1, 0, 0);
    tick(); v = 1'b0;
    chk4("ovr_c1", 4'b0100, 1, 0, 1);
    tick(); chk4("ovr_c2", 4'b0100, 1, 0, 1);
    tick(); chk4("ovr_c3", 4'b0100, 1, 0, 1);
    tick(); chk4("ovr_gap", 4'b0000, 1, 1, 1);
    tick(); chk4("ovr_idle", 4'b0000, 0, 0, 1);
    tick(); chk4("ovr_sticky", 4'b0000, 0, 0, 1);
    clr = 1'b1;
    tick(); clr = 1'b0;
    chk4("ovr_clear", 4'b0000, 0, 0, 0);

    // Clear coinciding with a new overrun: set wins.
    v = 1'b1; y = 2'd0;
    tick(); clr = 1'b1;
    chk4("setwin_c0", 4'b0001, 1, 0, 0);
    tick(); v = 1'b0; clr = 1'b0;
    chk4("setwin_c1", 4'b0001, 1, 0, 1);
    tick(); chk4("setwin_c2", 4'b0001, 1, 0, 1);
    tick(); chk4("setwin_c3", 4'b0001, 1, 0, 1);
    tick(); chk4("setwin_gap", 4'b0000, 1, 1, 1);
    tick(); chk4("setwin_idle", 4'b0000, 0, 0, 1);
    clr = 1'b1;
    tick(); clr = 1'b0;
    chk4("setwin_clear", 4'b0000, 0, 0, 0);

    // Back-to-back with V held high: Y=1 then Y=2.
    v = 1'b1; y = 2'd1;
    tick(); y = 2'd2;
    chk4("b2b_d1_c0", 4'b0010, 1, 0, 0);
    for (int k = 1; k < 4; k++) begin
      tick(); chk4("b2b_d1_ck", 4'b0010, 1, 0, 1);
    end
    tick(); chk4("b2b_gap", 4'b0000, 1, 1, 1);
    tick(); chk4("b2b_idle", 4'b0000, 0, 0, 1);
    tick(); v = 1'b0;
    chk4("b2b_d2_c0", 4'b0100, 1, 0, 1);
    for (int k = 1; k < 4; k++) begin
      tick(); chk4("b2b_d2_ck", 4'b0100, 1, 0, 1);
    end
    tick(); chk4("b2b_gap2", 4'b0000, 1, 1, 1);
    tick(); chk4("b2b_idle2", 4'b0000, 0, 0, 1);
    clr = 1'b1;
    tick(); clr = 1'b0;
    chk4("b2b_clear", 4'b0000, 0, 0, 0);

    // Reset on the second DRIVE cycle aborts without DONE.
    v = 1'b1; y = 2'd0;
    tick(); v = 1'b0;
    chk4("abort_c0", 4'b0001, 1, 0, 0);
    tick(); chk4("abort_c1", 4'b0001, 1, 0, 0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk4("abort_rst", 4'b0000, 0, 0, 0);
    tick(); chk4("abort_nodone", 4'b0000, 0, 0, 0);

    // PULSE_LEN=1 build: single DRIVE cycle, DONE the next.
    chk1("pl1_idle", 4'b0000, 0, 0, 0);
    v_b = 1'b1; y_b = 2'd3;
    tick(); v_b = 1'b0;
    chk1("pl1_drive", 4'b1000, 1, 0, 0);
    tick(); chk1("pl1_gap", 4'b0000, 1, 1, 0);
    tick(); chk1("pl1_idle2", 4'b0000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
